dvp_cam_emulator: RTL and testbench

//  Transmit side of the OV7660-style DVP camera bus: drives VSYNC/HREF/D[7:0] as the sensor would.

---
 rtl/dvp_cam_emulator.sv | 151 +++++++++++++++
 tb/tb_dvp_cam_emulator.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_cam_emulator.sv
// dvp_cam_emulator: OV7660-style DVP transmit emulator that streams RGB565 pixels as VSYNC/HREF/D[7:0]
//
// Ports:
//   fclk       byte clock of the emulated bus
//   rst_n      asynchronous active-low reset
//   start      pulse: begin streaming frames
//   stop       pulse: finish the current frame, then idle
//   test_mode  selects the internal line/column pattern (CAM_EMU_TESTPATTERN_EN builds only)
//   pix_in     RGB565 pixel, sent high byte first
//   pix_valid  pix_in valid
//   pix_ready  pixel taken this cycle if pix_valid (cycle before each high-byte slot)
//   cam_vsync  DVP VSYNC
//   cam_href   DVP HREF
//   cam_dout   DVP data, 0x00 whenever HREF is low
//   busy       not idle
//   underflow  sticky: a byte slot had no pixel; cleared by start
//   frame_cnt  completed frames, wraps at 16 bits
//
// Optional feature macro: CAM_EMU_TESTPATTERN_EN
module dvp_cam_emulator #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int VBP_LINES   = 17,
    parameter int VFP_LINES   = 10
) (
    input  logic        fclk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        test_mode,
    input  logic [15:0] pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_dout,
    output logic        busy,
    output logic        underflow,
    output logic [15:0] frame_cnt
);
    localparam int LP = 2 * H_ACTIVE + H_BLANK;
    localparam int HW = $clog2(LP);
    localparam int M1 = V_ACTIVE > VSYNC_LINES ? V_ACTIVE : VSYNC_LINES;
    localparam int M2 = VBP_LINES > VFP_LINES ? VBP_LINES : VFP_LINES;
    localparam int ML = M1 > M2 ? M1 : M2;
    localparam int LW = $clog2(ML + 1);
    localparam logic [HW-1:0] H_LAST = HW'(LP - 1);
    localparam logic [HW-1:0] H_HREF = HW'(2 * H_ACTIVE);

    typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

    state_t          state_q, state_d, nxt, after_frame;
    logic [HW-1:0]   h_q, h_d;
    logic [LW-1:0]   l_q, l_d, l_last;
    logic            line_end, ph_end, fin;
    logic            stop_q, stop_d, uf_q, uf_d;
    logic            vsync_q, href_q, href_d, tp;
    logic [7:0]      dout_q, dout_d, lo_q, lo_d, hi, pat;
    logic [15:0]     frame_cnt_q;

    // h_q/l_q give the position of the cycle currently on the bus; the *_d values
    // are the next cycle's position, so registering outputs from them keeps the
    // DVP outputs registered and aligned with state_q.
    always_comb begin
        l_last = state_q == VSYNC  ? LW'(VSYNC_LINES - 1) :
                 state_q == VBP    ? LW'(VBP_LINES - 1) :
                 state_q == ACTIVE ? LW'(V_ACTIVE - 1) : LW'(VFP_LINES - 1);
        line_end = h_q == H_LAST;
        ph_end = state_q != IDLE && line_end && l_q == l_last;
        fin = ph_end && (state_q == VFP || (state_q == ACTIVE && VFP_LINES == 0));
        after_frame = (stop_q || stop) ? IDLE : VSYNC;
        nxt = state_q == VSYNC  ? (VBP_LINES > 0 ? VBP : ACTIVE) :
              state_q == VBP    ? ACTIVE :
              state_q == ACTIVE ? (VFP_LINES > 0 ? VFP : after_frame) : after_frame;
        state_d = state_q;
        h_d = h_q;
        l_d = l_q;
        if (state_q == IDLE) begin
            state_d = start ? VSYNC : IDLE;
        end else if (line_end) begin
            h_d = '0;
            l_d = ph_end ? '0 : l_q + 1'b1;
            state_d = ph_end ? nxt : state_q;
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    // A pixel is requested one cycle ahead of every even (high-byte) HREF slot.
    assign href_d    = state_d == ACTIVE && h_d < H_HREF;
    assign pix_ready = href_d && !h_d[0] && !tp;
    assign hi        = pix_valid ? pix_in[15:8] : 8'h00;
    assign lo_d      = pix_ready ? (pix_valid ? pix_in[7:0] : 8'h00) : lo_q;
    assign dout_d    = !href_d ? 8'h00 : tp ? pat : h_d[0] ? lo_q : hi;
    assign stop_d    = state_d == IDLE ? 1'b0 : (stop_q || (stop && (state_q != IDLE || start)));
    assign uf_d      = (state_q == IDLE && start) ? 1'b0 : (uf_q || (pix_ready && !pix_valid));

`ifdef CAM_EMU_TESTPATTERN_EN
    logic tp_q;

    // Pattern selection is captured at start and held for the whole run.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) tp_q <= 1'b0;
        else if (state_q == IDLE && start) tp_q <= test_mode;
    end

    assign tp  = tp_q;
    assign pat = h_d[0] ? 8'(h_d >> 1) : 8'(l_d);
`else
    logic unused_test_mode;

    assign unused_test_mode = test_mode;
    assign tp  = 1'b0;
    assign pat = 8'h00;
`endif

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            h_q         <= '0;
            l_q         <= '0;
            stop_q      <= 1'b0;
            uf_q        <= 1'b0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            dout_q      <= 8'h00;
            lo_q        <= 8'h00;
            frame_cnt_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            l_q         <= l_d;
            stop_q      <= stop_d;
            uf_q        <= uf_d;
            vsync_q     <= state_d == VSYNC;
            href_q      <= href_d;
            dout_q      <= dout_d;
            lo_q        <= lo_d;
            frame_cnt_q <= fin ? frame_cnt_q + 16'd1 : frame_cnt_q;
        end
    end

    assign cam_vsync = vsync_q;
    assign cam_href  = href_q;
    assign cam_dout  = dout_q;
    assign busy      = state_q != IDLE;
    assign underflow = uf_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_dvp_cam_emulator.sv
// tb_dvp_cam_emulator: self-checking bench for dvp_cam_emulator with small frame timing
module tb_dvp_cam_emulator;
    localparam int HA = 4, VA = 2, HB = 3, VS = 1, VBP = 1, VFP = 1;
    localparam int LP = 2 * HA + HB;
    localparam int FL = LP * (VS + VBP + VA + VFP);
`ifdef CAM_EMU_TESTPATTERN_EN
    localparam bit TP_ON = 1'b1;
`else
    localparam bit TP_ON = 1'b0;
`endif

    logic        fclk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, test_mode = 1'b0, pix_valid = 1'b0;
    logic [15:0] pix_in = 16'h0000;
    logic        pix_ready, cam_vsync, cam_href, busy, underflow;
    logic [7:0]  cam_dout;
    logic [15:0] frame_cnt;
    int          n_cmp = 0, n_bad = 0, fc_base = 0;

    typedef struct {
        int          k;
        logic        vs;
        logic        hr;
        logic [7:0]  d;
        logic [15:0] fc;
    } vec_t;

    dvp_cam_emulator #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
        .VSYNC_LINES(VS), .VBP_LINES(VBP), .VFP_LINES(VFP)
    ) dut (
        .fclk(fclk), .rst_n(rst_n), .start(start), .stop(stop), .test_mode(test_mode),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_dout(cam_dout),
        .busy(busy), .underflow(underflow), .frame_cnt(frame_cnt)
    );

    always #5 fclk = ~fclk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
        end
    endtask

    // Bus position of cycle k of a continuous stream (k=0 is the first cycle after start).
    function automatic void pos(input int k, output bit hr, output bit vs, output int a, output int col);
        int ln;
        ln  = (k % FL) / LP;
        col = (k % FL) % LP;
        vs  = ln < VS;
        a   = ln - VS - VBP;
        hr  = a >= 0 && a < VA && col < 2 * HA;
    endfunction

    // Random run checked against the frame-arithmetic model; stop_k<0 means stop with start.
    task automatic run_model(input int stop_k, input bit tm, input int vpct);
        logic [15:0] q[$];
        bit          uf, tpe, hr, vs, hrn, vsn, rdy, act;
        int          a, col, an, coln, last;
        logic [7:0]  ed;
        uf   = 1'b0;
        tpe  = tm && TP_ON;
        last = stop_k < 0 ? FL : (stop_k / FL + 1) * FL;
        @(negedge fclk);
        start = 1'b1;
        stop = stop_k < 0;
        test_mode = tm;
        for (int k = 0; k < last + 12; k++) begin
            @(negedge fclk);
            act = k < last;
            pos(k, hr, vs, a, col);
            pos(k + 1, hrn, vsn, an, coln);
            hr  = act && hr;
            vs  = act && vs;
            rdy = act && hrn && (coln % 2 == 0) && !tpe;
            ed  = 8'h00;
            if (hr && tpe) ed = (col % 2 != 0) ? 8'(col / 2) : 8'(a);
            else if (hr && q.size() > 0) begin
                ed = (col % 2 != 0) ? q[0][7:0] : q[0][15:8];
                if (col % 2 != 0) q.delete(0);
            end
            chk($sformatf("vsync k=%0d", k), cam_vsync, vs);
            chk($sformatf("href k=%0d", k), cam_href, hr);
            chk($sformatf("dout k=%0d", k), cam_dout, ed);
            chk($sformatf("pix_ready k=%0d", k), pix_ready, rdy);
            chk($sformatf("busy k=%0d", k), busy, act);
            chk($sformatf("underflow k=%0d", k), underflow, uf);
            chk($sformatf("frame_cnt k=%0d", k), frame_cnt, 16'(fc_base + (act ? k : last) / FL));
            start     = act && k > 0 && $urandom_range(15) == 0;
            stop      = k == stop_k || (act && k > stop_k && $urandom_range(7) == 0);
            test_mode = 1'($urandom);
            pix_valid = $urandom_range(99) < vpct;
            pix_in    = 16'($urandom);
            if (rdy) begin
                q.push_back(pix_valid ? pix_in : 16'h0000);
                uf = uf || !pix_valid;
            end
        end
        fc_base += last / FL;
        start = 1'b0;
        stop = 1'b0;
    endtask

`ifdef CAM_EMU_TESTPATTERN_EN
    task automatic tp_check();
        logic [7:0] exp6 [8];
        exp6 = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h03};
        @(negedge fclk);
        start = 1'b1;
        stop = 1'b1;
        test_mode = 1'b1;
        for (int k = 0; k < FL; k++) begin
            @(negedge fclk);
            start = 1'b0;
            stop = 1'b0;
            test_mode = 1'b0;
            pix_valid = 1'b0;
            chk($sformatf("tp_ready k=%0d", k), pix_ready, 1'b0);
            if (k >= 33 && k <= 40) chk($sformatf("tp_dout k=%0d", k), cam_dout, exp6[k-33]);
        end
        fc_base += 1;
    endtask
`endif

    initial begin
        vec_t        tab[14];
        logic [15:0] pix_tab[8];
        int          idx, ti, kfall;
        tab = '{
            '{0,  1'b1, 1'b0, 8'h00, 16'd0}, '{10, 1'b1, 1'b0, 8'h00, 16'd0},
            '{11, 1'b0, 1'b0, 8'h00, 16'd0}, '{21, 1'b0, 1'b0, 8'h00, 16'd0},
            '{22, 1'b0, 1'b1, 8'hA1, 16'd0}, '{23, 1'b0, 1'b1, 8'hB2, 16'd0},
            '{24, 1'b0, 1'b1, 8'hC3, 16'd0}, '{29, 1'b0, 1'b1, 8'h18, 16'd0},
            '{30, 1'b0, 1'b0, 8'h00, 16'd0}, '{33, 1'b0, 1'b1, 8'h29, 16'd0},
            '{40, 1'b0, 1'b1, 8'h90, 16'd0}, '{41, 1'b0, 1'b0, 8'h00, 16'd0},
            '{54, 1'b0, 1'b0, 8'h00, 16'd0}, '{55, 1'b1, 1'b0, 8'h00, 16'd1}};
        pix_tab = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718, 16'h293A, 16'h4B5C, 16'h6D7E, 16'h8F90};

        repeat (3) @(negedge fclk);
        chk("rst_vsync", cam_vsync, 1'b0);
        chk("rst_href", cam_href, 1'b0);
        chk("rst_dout", cam_dout, 8'h00);
        chk("rst_ready", pix_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_underflow", underflow, 1'b0);
        chk("rst_frame_cnt", frame_cnt, 16'h0000);
        rst_n = 1'b1;

        idx = 0;
        ti = 0;
        kfall = -1;
        @(negedge fclk);
        start = 1'b1;
        for (int k = 0; k < 200 && kfall < 0; k++) begin
            @(negedge fclk);
            start = 1'b0;
            if (ti < 14 && tab[ti].k == k) begin
                chk($sformatf("t1_vsync k=%0d", k), cam_vsync, tab[ti].vs);
                chk($sformatf("t1_href k=%0d", k), cam_href, tab[ti].hr);
                chk($sformatf("t1_dout k=%0d", k), cam_dout, tab[ti].d);
                chk($sformatf("t1_frame_cnt k=%0d", k), frame_cnt, tab[ti].fc);
                ti++;
            end
            if (!busy) kfall = k;
            stop = k == 60;
            pix_valid = 1'b1;
            pix_in = pix_tab[idx % 8];
            if (pix_ready) idx++;
        end
        chk("t1_rows", ti, 14);
        chk("t1_busy_fall", kfall, 110);
        chk("t1_frame_cnt_end", frame_cnt, 16'd2);
        fc_base = 2;

        idx = 0;
        @(negedge fclk);
        start = 1'b1;
        for (int k = 0; k < 70; k++) begin
            @(negedge fclk);
            start = 1'b0;
            if (k == 22) chk("uf_dout22", cam_dout, 8'h11);
            if (k == 23) chk("uf_flag23", underflow, 1'b0);
            if (k == 24) chk("uf_dout24", cam_dout, 8'h00);
            if (k == 24) chk("uf_flag24", underflow, 1'b1);
            if (k == 25) chk("uf_dout25", cam_dout, 8'h00);
            if (k == 26) chk("uf_dout26", cam_dout, 8'h33);
            if (k == 27) chk("uf_dout27", cam_dout, 8'h33);
            if (k == 60) chk("uf_sticky", underflow, 1'b1);
            if (k == 60) chk("uf_idle", busy, 1'b0);
            stop = k == 30;
            pix_valid = idx != 1;
            pix_in = 16'(32'h1111 * (idx + 1));
            if (pix_ready) idx++;
        end
        fc_base += 1;

        run_model(-1, 1'b0, 100);
        run_model($urandom_range(3 * FL - 1), 1'b0, 80);
        run_model($urandom_range(2 * FL), 1'b1, 70);
        run_model(-1, 1'b1, 90);
`ifdef CAM_EMU_TESTPATTERN_EN
        tp_check();
`endif

        @(negedge fclk);
        start = 1'b1;
        for (int k = 0; k < 26; k++) begin
            @(negedge fclk);
            start = 1'b0;
            pix_valid = 1'b1;
            pix_in = 16'hBEEF;
        end
        chk("pre_rst_href", cam_href, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_vsync", cam_vsync, 1'b0);
        chk("arst_href", cam_href, 1'b0);
        chk("arst_dout", cam_dout, 8'h00);
        chk("arst_ready", pix_ready, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_frame_cnt", frame_cnt, 16'h0000);
        @(negedge fclk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge fclk);
            chk("post_rst_busy", busy, 1'b0);
            chk("post_rst_vsync", cam_vsync, 1'b0);
            chk("post_rst_href", cam_href, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
